pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (generalises the fixed EX/MEM latch).
//  Carries NUM_CH data words plus FLAG_W side flags with a valid/ready handshake.
//  Adds stall (backpressure), flush and bubble insertion, plus a stall-cycle counter.
//  Instantiated between any two core stages (F/D, D/E, E/M, M/W).
// PARAMETERS
//  NUM_CH  4   number of payload words (e.g. instr, PC, rt data, ALU result)
//  CH_W    32  width of each payload word
//  FLAG_W  1   width of side-flag bundle (e.g. check bit)
//  CNT_W   16  width of stall-cycle counter
// PORTS
//  clk        in   1             clock, all state on rising edge
//  reset      in   1             asynchronous, active-low reset
//  flush      in   1             sync kill: drop all held entries
//  in_valid   in   1             upstream entry present
//  in_ready   out  1             this stage accepts entry this cycle
//  in_data    in   NUM_CH*CH_W   payload; word k = bits [k*CH_W +: CH_W]
//  in_flag    in   FLAG_W        side flags
//  out_valid  out  1             entry present to downstream
//  out_ready  in   1             downstream accepts this cycle
//  out_data   out  NUM_CH*CH_W   payload to downstream
//  out_flag   out  FLAG_W        side flags to downstream
//  stall_cnt  out  CNT_W         cycles with out_valid=1 and out_ready=0 (saturating)
// BEHAVIOUR
//  - Reset (reset=0, async): all valid bits 0, out_data=0, out_flag=0, stall_cnt=0.
//  - Transfer in: in_valid & in_ready at rising edge; transfer out: out_valid & out_ready.
//  - Latency: an accepted entry appears on out_* the next cycle; throughput 1/cycle.
//  - Bubble = NOP: whenever out_valid=0, out_data and out_flag are all-zero.
//  - Hold: while out_valid & ~out_ready, out_data/out_flag stay bit-stable.
//  - flush=1: next edge clears every valid bit and zeroes payload;
//    in_ready forced 0 that cycle (no entry accepted); takes priority over all
//    transfers; reset takes priority over flush.
//  - Base mode (single slot): in_ready = ~flush & (~out_valid | out_ready),
//    a combinational path from out_ready.
//    Next: load in_* if in transfer; else if out transfer, go empty (zeroed); else hold.
//  - Simultaneous in and out transfer: slot reloads with new entry, out_valid stays 1.
//  - stall_cnt: +1 per edge where out_valid & ~out_ready; saturates at all-ones;
//    not cleared by flush, only by reset.
//  - Reset deasserting mid-stream: first edge after release behaves as empty stage.
// CONFIGURATION
//  PIPE_STAGE_REG_SKID_EN defined: two-entry skid buffer (main slot M + skid slot S).
//    in_ready = ~flush & ~S_valid, driven from a register (no comb path from out_ready).
//    Out slot free (~M_valid | out_ready):
//      - S_valid: M <= S, S cleared.
//      - else: M <= input if transfer, else empty.
//    Out slot blocked: input transfer goes to S.
//    Order preserved; latency 1; flush clears M and S.
//  Undefined: base single-slot mode above; no S storage synthesised.
// STRUCTURE
//  Shared package pipe_pkg:
//    CH_W default, NOP word constant (32'd0),
//    typedef for the packed payload+flag bundle, stall-counter width constant.
//  Sub-module pipe_slot: one valid bit + payload register with load/clear/hold
//  controls; instantiated once (M), twice with skid (M, S).
// TESTING
//  1 reset=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, stall_cnt=0 immediately (async).
//  2 Stream 0x100,0x104,0x108 with out_ready=1 -> each on out_data one cycle later, no gaps, stall_cnt=0.
//  3 Load 0xDEAD, hold out_ready=0 for 5 cycles -> out_data=0xDEAD stable, stall_cnt=5; base in_ready=0.
//  4 Skid build, out_ready=0, offer A then B ->
//    A in M, B in S, in_ready=0; release -> A then B in order.
//  5 flush=1 with entry held and in_valid=1 ->
//    in_ready=0 that cycle; next cycle out_valid=0, out_data=0; stall_cnt unchanged.
//  6 CNT_W=4, stall 20 cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register: default widths,
// the NOP payload word and the packed payload+flag bundle.
package pipe_pkg;
    localparam int NUM_CH_DEF  = 4;
    localparam int CH_W_DEF    = 32;
    localparam int FLAG_W_DEF  = 1;
    localparam int STALL_CNT_W = 16;

    // A bubble carries this word on every channel.
    localparam logic [CH_W_DEF-1:0] NOP_WORD = 32'd0;

    typedef struct packed {
        logic [FLAG_W_DEF-1:0]          flag;
        logic [NUM_CH_DEF*CH_W_DEF-1:0] data;
    } pipe_bundle_t;
endpackage

// File: rtl/pipe_slot.sv
// One storage slot: valid bit plus payload register, clear > load > hold.
// Latency: register, 1 cycle. Backpressure: none, controls come from the owner.
// A cleared slot zeroes its payload so an empty slot always presents a NOP.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (clear) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush, NOP bubbles and a saturating stall counter.
// Latency: 1 cycle, 1 entry/cycle. Backpressure: out_ready gates in_ready combinationally;
// with PIPE_STAGE_REG_SKID_EN a skid slot absorbs one entry so in_ready comes from a register.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = CH_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    input  logic [FLAG_W-1:0]      in_flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*CH_W-1:0] out_data,
    output logic [FLAG_W-1:0]      out_flag,
    output logic [CNT_W-1:0]       stall_cnt
);
    localparam int DW = NUM_CH * CH_W;
    localparam int BW = DW + FLAG_W;

    logic [BW-1:0] in_bundle;
    logic [BW-1:0] m_d;
    logic [BW-1:0] m_q;
    logic          m_vld;
    logic          m_load;
    logic          m_clr;
    logic          in_xfer;

    assign in_bundle = {in_flag, in_data};
    assign in_xfer   = in_valid & in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [BW-1:0] s_q;
    logic          s_vld;
    logic          s_load;
    logic          s_clr;
    logic          out_free;

    assign out_free = ~m_vld | out_ready;
    assign in_ready = ~flush & ~s_vld;

    // S only fills while M is blocked, so M empty implies S empty and order holds.
    always_comb begin
        m_d    = in_bundle;
        m_load = 1'b0;
        m_clr  = 1'b0;
        s_load = 1'b0;
        s_clr  = 1'b0;
        if (flush) begin
            m_clr = 1'b1;
            s_clr = 1'b1;
        end else if (out_free) begin
            if (s_vld) begin
                m_d    = s_q;
                m_load = 1'b1;
                s_clr  = 1'b1;
            end else if (in_xfer) begin
                m_load = 1'b1;
            end else begin
                m_clr = 1'b1;
            end
        end else if (in_xfer) begin
            s_load = 1'b1;
        end
    end

    pipe_slot #(.W(BW)) u_skid_slot (
        .clk   (clk),
        .reset (reset),
        .load  (s_load),
        .clear (s_clr),
        .d     (in_bundle),
        .vld   (s_vld),
        .q     (s_q)
    );
`else
    assign in_ready = ~flush & (~m_vld | out_ready);

    always_comb begin
        m_d    = in_bundle;
        m_load = in_xfer;
        m_clr  = flush | (m_vld & out_ready & ~in_xfer);
    end
`endif

    pipe_slot #(.W(BW)) u_main_slot (
        .clk   (clk),
        .reset (reset),
        .load  (m_load),
        .clear (m_clr),
        .d     (m_d),
        .vld   (m_vld),
        .q     (m_q)
    );

    assign out_valid = m_vld;
    assign out_data  = m_q[DW-1:0];
    assign out_flag  = m_q[BW-1:DW];

    // Counts stalled edges; flush leaves it alone, only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (m_vld & ~out_ready & ~(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue scoreboard of accepted entries, directed cases, random traffic.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 32;
    localparam int FLAG_W = 1;
    localparam int CNT_W  = 4;
    localparam int DW     = NUM_CH * CH_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic [FLAG_W-1:0] in_flag = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [FLAG_W-1:0] out_flag;
    logic [CNT_W-1:0]  stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    pipe_bundle_t sb[$];
    int           exp_stall = 0;
    bit           in_rdy_exp = 1'b0;

    pipe_stage_reg #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .FLAG_W (FLAG_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_flag   (in_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [CH_W-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++) r[k*CH_W +: CH_W] = x + CH_W'(k);
        return r;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input logic [FLAG_W-1:0] f,
                        input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_flag   = f;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Scoreboard push: an entry offered while the reference says "ready" is accepted.
    always @(posedge clk) begin
        if (reset && !flush && in_valid && in_rdy_exp)
            sb.push_back('{flag: in_flag, data: in_data});
    end

    // Monitor: outputs must present the oldest accepted entry, or a NOP bubble.
    always @(negedge clk) begin
        bit exp_vld;
        bit rdy;
        if (!reset) begin
            sb.delete();
            exp_stall  = 0;
            in_rdy_exp = 1'b0;
        end else begin
            exp_vld = (sb.size() != 0);
            chk("out_valid", out_valid, exp_vld);
            if (exp_vld) begin
                chk("out_data", out_data, sb[0].data);
                chk("out_flag", out_flag, sb[0].flag);
            end else begin
                chk("bubble_data", out_data, {NUM_CH{NOP_WORD}});
                chk("bubble_flag", out_flag, '0);
            end
            chk("stall_cnt", stall_cnt, exp_stall);
`ifdef PIPE_STAGE_REG_SKID_EN
            rdy = !flush && (sb.size() < 2);
`else
            rdy = !flush && (!exp_vld || out_ready);
`endif
            chk("in_ready", in_ready, rdy);
            in_rdy_exp = rdy;
            if (flush) sb.delete();
            else if (exp_vld && out_ready) void'(sb.pop_front());
            if (exp_vld && !out_ready && exp_stall < CNT_MAX) exp_stall++;
        end
    end

    initial begin
        logic [DW-1:0] rd;

        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_flag", out_flag, '0);
        chk("rst_stall_cnt", stall_cnt, '0);
        step(0, '0, '0, 1, 0);
        reset = 1'b1;

        // Back-to-back stream, one cycle latency, no gaps.
        for (int i = 0; i < 4; i++) begin
            step(i < 3, mk(32'h100 + 32'(4 * i)), '0, 1, 0);
            if (i > 0) begin
                #2;
                chk("stream_valid", out_valid, 1'b1);
                chk("stream_data", out_data, mk(32'h100 + 32'(4 * (i - 1))));
            end
        end
        step(0, '0, '0, 1, 0);
        #2;
        chk("stream_stall", stall_cnt, '0);

        // Hold under backpressure for five cycles.
        step(1, mk(32'hDEAD), 1'b1, 0, 0);
        repeat (5) step(0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        chk("hold_stall5", stall_cnt, 4'd5);
        chk("hold_data", out_data, mk(32'hDEAD));
        chk("hold_flag", out_flag, 1'b1);
`ifdef PIPE_STAGE_REG_SKID_EN
        chk("hold_in_ready", in_ready, 1'b1);
`else
        chk("hold_in_ready", in_ready, 1'b0);
`endif

        // Flush with an entry held and a new one offered.
        in_valid  = 1'b1;
        in_data   = mk(32'hBEEF);
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 1'b0);
        step(0, '0, '0, 1, 0);
        #2;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_data", out_data, '0);
        chk("flush_stall_kept", stall_cnt, 4'd5);

        // Backpressure with two offers.
        step(1, mk(32'hA000), '0, 0, 0);
        step(1, mk(32'hB000), '0, 0, 0);
        #2;
`ifdef PIPE_STAGE_REG_SKID_EN
        chk("skid_rdy_b", in_ready, 1'b1);
        step(1, mk(32'hC000), '0, 0, 0);
        #2;
        chk("skid_full_rdy", in_ready, 1'b0);
        chk("skid_m_is_a", out_data, mk(32'hA000));
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);
        #2;
        chk("skid_then_b", out_data, mk(32'hB000));
`else
        chk("base_blocked_rdy", in_ready, 1'b0);
        chk("base_m_is_a", out_data, mk(32'hA000));
        step(0, '0, '0, 1, 0);
`endif
        repeat (2) step(0, '0, '0, 1, 0);

        // Asynchronous reset in the middle of a stalled entry.
        step(1, mk(32'h77), '0, 0, 0);
        repeat (2) step(0, '0, '0, 0, 0);
        #2;
        chk("mid_pre_valid", out_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_stall", stall_cnt, '0);
        step(0, '0, '0, 1, 0);
        reset = 1'b1;
        step(1, mk(32'h88), '0, 1, 0);
        step(0, '0, '0, 1, 0);

        // Saturation of the 4-bit stall counter.
        step(1, mk(32'h55), '0, 0, 0);
        repeat (20) step(0, '0, '0, 0, 0);
        @(posedge clk);
        #1;
        chk("stall_saturate", stall_cnt, 4'd15);
        step(0, '0, '0, 1, 0);

        // Random traffic with occasional flushes.
        repeat (400) begin
            for (int k = 0; k < NUM_CH; k++) rd[k*CH_W +: CH_W] = $urandom;
            step($urandom_range(0, 9) < 7, rd, FLAG_W'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        repeat (4) step(0, '0, '0, 1, 0);
        @(negedge clk);
        chk("drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
